ram8_bank: RTL and testbench
============================

Name: ram8_bank

Overview:
- 8-entry x 16-bit register bank: the sequential stage directly downstream of the one-hot load decoder (DMux8Way) and 8-way read selector (Mux8Way16).
- Write path: load routed to one of 8 registers by address. Read path: the addressed register selected combinationally onto out.
- Adds a hardware clear sequencer that zeroes all 8 entries in an 8-cycle sweep.
- Serves as the building block for larger RAM (RAM64 and up) and as scratch storage for the CPU datapath.

Parameters:
- WIDTH, 16, data width of each entry and of in/out.
- AW, 3, address width. Fixed at 3 (depth 8); other values are unsupported.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in  input  WIDTH  write data.
- load  input  1  write enable for the entry at address.
- address  input  AW  entry select for both read and write.
- clr  input  1  request to start a clear sweep.
- out  output  WIDTH  contents of entry[address], combinational.
- busy  output  1  high while the clear sweep runs.
- clr_done  output  1  one-cycle pulse marking the end of the sweep.

Behaviour:
- Reset (rst_n=0, asynchronous): all 8 entries = 0, state = IDLE, sweep counter = 0, busy = 0, clr_done = 0. out therefore reads 0.
- Reset asserted mid-sweep aborts the sweep immediately. No clr_done pulse is produced.
- Read: out = entry[address] with zero latency; it follows address changes within the same cycle.
- Write (IDLE, load=1, clr=0): entry[address] <= in at the rising edge.
  - out shows the old value during the write cycle and the new value from the next cycle.
  - No write-through bypass.
- Only the addressed entry changes on a write. The load decode is one-hot via DMux8Way semantics.
- FSM has two states, IDLE and SWEEP.
  - IDLE, clr=1 at edge -> SWEEP, counter <= 0. clr wins over load in the same cycle; that load is dropped.
  - SWEEP: each edge, entry[counter] <= 0 and counter <= counter+1.
  - SWEEP, edge with counter==7 -> entry[7] <= 0, state IDLE, clr_done = 1 for the following cycle only.
- busy = (state==SWEEP). It is registered: it rises the cycle after clr is sampled and stays high exactly 8 cycles.
- While busy:
  - load is ignored and no user write occurs.
  - clr is ignored; the sweep is not restarted.
  - Reads still function: entries already swept read 0, others keep their old data.
- clr asserted in the same cycle clr_done is high is accepted, because the state is IDLE. A new sweep starts.
- Counter wraps 7 -> 0 at sweep end; its value in IDLE is don't-care but is reset to 0.
- No arithmetic beyond the 3-bit counter increment (mod 8).

Decomposition:
- Shared include file holds WIDTH=16, AW=3, DEPTH=8 and the state encoding (IDLE=1'b0, SWEEP=1'b1). RAM64 and the PC reuse it.
- One sub-module: register16, a 16-bit register with load and async active-low reset, instantiated 8 times.
  - Its write enable = (decoded load & ~busy) | (sweep select), with data muxed between in and 0.
  - Decoded load comes from DMux8Way; out comes from Mux8Way16.

Test Plan:
- Reset then read: rst_n pulse low, sweep address 0..7 -> out=0x0000 for every address; busy=0, clr_done=0.
- Write/read-back: load=1, write address k with in=0x1111*k for k=0..7.
  - Expected: out at address 3 equals 0x3333 only from the cycle after the write, and shows the old value in the write cycle.
  - Expected: all other entries are unchanged.
- Clear sweep: fill all entries with 0xA5A5, pulse clr for one cycle.
  - Expected: busy high for exactly 8 cycles, then a clr_done single-cycle pulse, then all out=0x0000.
  - Mid-sweep, address 7 still reads 0xA5A5 until the final sweep cycle.
- Blocked operations during sweep: load=1, address=2, in=0xBEEF while busy.
  - Expected: entry 2 ends as 0x0000.
  - Expected: a second clr pulse mid-sweep does not extend busy beyond 8 cycles.
- Priority: clr=1 and load=1 (address=5, in=0x1234) in the same IDLE cycle.
  - Expected: sweep starts and entry 5 = 0x0000 after the sweep.
- Async reset mid-sweep: drop rst_n on the 4th busy cycle without a clock edge.
  - Expected: busy=0 immediately and all entries 0.
  - Expected: no clr_done pulse afterwards, and normal writes work after release.

Source files
------------

// File: rtl/ram8_bank_pkg.sv
// rtl/ram8_bank_pkg.sv - shared sizes and sweep FSM encoding for the RAM8 bank family
package ram8_bank_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 3;
   localparam int DEPTH  = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } state_t;

endpackage

// File: rtl/ram8_bank_register16.sv
// rtl/ram8_bank_register16.sv - one bank entry: loadable register with async active-low reset
module register16
   import ram8_bank_pkg::*;
#(
   parameter int WIDTH = DATA_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   input  logic             load,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/ram8_bank.sv
// rtl/ram8_bank.sv - 8 x WIDTH register bank with combinational read and a clear-sweep sequencer
module ram8_bank
   import ram8_bank_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int AW    = ADDR_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in,
   input  logic             load,
   input  logic [AW-1:0]    address,
   input  logic             clr,
   output logic [WIDTH-1:0] out,
   output logic             busy,
   output logic             clr_done
);

   state_t           state;
   logic [AW-1:0]    cnt;
   logic [DEPTH-1:0] dec_load;
   logic [DEPTH-1:0] we;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         clr_done <= 1'b0;
      end else begin
         clr_done <= 1'b0;
         case (state)
            IDLE: begin
               if (clr) begin
                  state <= SWEEP;
                  cnt   <= '0;
               end
            end
            SWEEP: begin
               cnt <= cnt + 1'b1;
               if (cnt == AW'(DEPTH - 1)) begin
                  state    <= IDLE;
                  clr_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state == SWEEP);

   // One-hot load decode; a clr in IDLE takes priority and drops the same-cycle load.
   always_comb begin
      dec_load = '0;
      if (load && !clr) begin
         dec_load[address] = 1'b1;
      end
   end

   assign wdata = busy ? '0 : in;

   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      assign we[i] = (dec_load[i] & ~busy) | (busy & (cnt == AW'(i)));

      register16 #(.WIDTH(WIDTH)) u_reg (
         .clk   (clk),
         .rst_n (rst_n),
         .d     (wdata),
         .load  (we[i]),
         .q     (q[i])
      );
   end

   assign out = q[address];

endmodule

// File: tb/tb_ram8_bank.sv
// tb/tb_ram8_bank.sv - directed self-checking bench for ram8_bank
module tb_ram8_bank;

   logic        clk;
   logic        rst_n;
   logic [15:0] in;
   logic        load;
   logic [2:0]  address;
   logic        clr;
   logic [15:0] out;
   logic        busy;
   logic        clr_done;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        ld;
      logic [2:0]  a;
      logic [15:0] d;
      logic [15:0] exp;
   } vec_t;

   vec_t vt[$];

   ram8_bank dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in       (in),
      .load     (load),
      .address  (address),
      .clr      (clr),
      .out      (out),
      .busy     (busy),
      .clr_done (clr_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic add_vec(input logic ld, input logic [2:0] a, input logic [15:0] d,
                          input logic [15:0] exp);
      vec_t v;
      v.ld = ld; v.a = a; v.d = d; v.exp = exp;
      vt.push_back(v);
   endtask

   // Each cycle starts at a falling edge: drive inputs there, sample #1 later.
   task automatic write_word(input logic [2:0] a, input logic [15:0] d);
      @(negedge clk);
      load = 1'b1; address = a; in = d; clr = 1'b0;
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      load = 1'b0; clr = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; in = '0; load = 1'b0; address = '0; clr = 1'b0;

      for (int k = 0; k < 8; k++) add_vec(1'b1, 3'(k), 16'(16'h1111 * k), 16'h0000);
      for (int k = 0; k < 8; k++) add_vec(1'b0, 3'(k), 16'h0000, 16'(16'h1111 * k));
      add_vec(1'b1, 3'd3, 16'hCAFE, 16'h3333);
      add_vec(1'b0, 3'd3, 16'h0000, 16'hCAFE);
      add_vec(1'b0, 3'd2, 16'h0000, 16'h2222);
      add_vec(1'b0, 3'd4, 16'h0000, 16'h4444);

      // Reset then read
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int a = 0; a < 8; a++) begin
         @(negedge clk);
         address = 3'(a);
         #1;
         chk($sformatf("reset_out[%0d]", a), out, 16'h0000);
      end
      chk("reset_busy", busy, 1'b0);
      chk("reset_clr_done", clr_done, 1'b0);

      // Write / read-back table
      foreach (vt[i]) begin
         @(negedge clk);
         load = vt[i].ld; address = vt[i].a; in = vt[i].d; clr = 1'b0;
         #1;
         chk($sformatf("vec%0d_out", i), out, vt[i].exp);
      end
      idle_cycle();

      // Clear sweep
      for (int a = 0; a < 8; a++) write_word(3'(a), 16'hA5A5);
      @(negedge clk);
      load = 1'b0; clr = 1'b1; address = 3'd7;
      #1 chk("sweep_busy_pre", busy, 1'b0);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         clr = 1'b0;
         #1;
         chk($sformatf("sweep_busy_c%0d", c), busy, 1'b1);
         chk($sformatf("sweep_done_c%0d", c), clr_done, 1'b0);
         chk($sformatf("sweep_a7_c%0d", c), out, 16'hA5A5);
      end
      @(negedge clk);
      #1;
      chk("sweep_busy_end", busy, 1'b0);
      chk("sweep_done_pulse", clr_done, 1'b1);
      @(negedge clk);
      #1 chk("sweep_done_drop", clr_done, 1'b0);
      for (int a = 0; a < 8; a++) begin
         @(negedge clk);
         address = 3'(a);
         #1 chk($sformatf("sweep_zero[%0d]", a), out, 16'h0000);
      end

      // Blocked load and clr during sweep
      write_word(3'd2, 16'h5555);
      write_word(3'd6, 16'h6666);
      @(negedge clk);
      load = 1'b0; clr = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         load = 1'b1; address = 3'd2; in = 16'hBEEF; clr = (c == 3);
         #1;
         chk($sformatf("blk_busy_c%0d", c), busy, 1'b1);
         if (c == 0) chk("blk_a2_old", out, 16'h5555);
         if (c >= 3) chk($sformatf("blk_a2_c%0d", c), out, 16'h0000);
      end
      @(negedge clk);
      load = 1'b0; clr = 1'b0;
      #1;
      chk("blk_busy_end", busy, 1'b0);
      chk("blk_done", clr_done, 1'b1);
      @(negedge clk);
      #1 chk("blk_no_restart", busy, 1'b0);
      @(negedge clk);
      address = 3'd2;
      #1 chk("blk_a2_final", out, 16'h0000);
      @(negedge clk);
      address = 3'd6;
      #1 chk("blk_a6_final", out, 16'h0000);

      // clr beats load; clr during clr_done is accepted
      write_word(3'd5, 16'h7777);
      @(negedge clk);
      load = 1'b1; address = 3'd5; in = 16'h1234; clr = 1'b1;
      @(negedge clk);
      load = 1'b0; clr = 1'b0;
      #1;
      chk("prio_busy", busy, 1'b1);
      chk("prio_a5_kept", out, 16'h7777);
      repeat (7) @(negedge clk);
      @(negedge clk);
      clr = 1'b1;
      #1 chk("prio_done", clr_done, 1'b1);
      @(negedge clk);
      clr = 1'b0;
      #1;
      chk("rearm_busy", busy, 1'b1);
      chk("prio_a5_zero", out, 16'h0000);
      repeat (7) @(negedge clk);
      @(negedge clk);
      #1 chk("rearm_done", clr_done, 1'b1);

      // Async reset mid-sweep
      for (int a = 0; a < 8; a++) write_word(3'(a), 16'(16'h1000 + a));
      @(negedge clk);
      load = 1'b0; clr = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         clr = 1'b0;
      end
      #1 chk("ar_busy_before", busy, 1'b1);
      #1 rst_n = 1'b0;
      #1 chk("ar_busy_now", busy, 1'b0);
      for (int a = 0; a < 8; a++) begin
         address = 3'(a);
         #1 chk($sformatf("ar_zero[%0d]", a), out, 16'h0000);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         #1 chk($sformatf("ar_no_done_c%0d", c), clr_done, 1'b0);
      end
      write_word(3'd4, 16'h4242);
      idle_cycle();
      address = 3'd4;
      #1 chk("ar_write_after", out, 16'h4242);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
